// File: rtl/de10_bus_pkg.sv
// Shared types and region-decode constants for the DE10-Lite system bus.
package de10_bus_pkg;

  localparam int unsigned TAG_HI = 31;
  localparam int unsigned TAG_LO = 22;
  localparam int unsigned TAG_W  = TAG_HI - TAG_LO + 1;

  localparam logic [TAG_W-1:0] SDRAM_TAG = '0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    M0,
    M1
  } master_e;

endpackage

// File: rtl/de10_region_decode.sv
// Region decode: maps an address tag to exactly one target select.
module de10_region_decode #(
  parameter int unsigned      TAG_W     = de10_bus_pkg::TAG_W,
  parameter logic [TAG_W-1:0] SDRAM_TAG = TAG_W'(de10_bus_pkg::SDRAM_TAG)
) (
  input  logic [TAG_W-1:0] tag_i,
  output logic             sel_sdram_c_o,
  output logic             sel_periph_c_o
);

  assign sel_sdram_c_o  = (tag_i == SDRAM_TAG);
  assign sel_periph_c_o = ~sel_sdram_c_o;

endmodule

// File: rtl/de10_bus_arbiter.sv
// Round-robin arbiter sharing the system bus between ifetch (m0) and data (m1)
// ports, with per-transaction target select and a BUSY-cycle timeout watchdog.
module de10_bus_arbiter #(
  parameter int unsigned                ADDR_W    = 32,
  parameter int unsigned                DATA_W    = 32,
  parameter int unsigned                TAG_HI    = de10_bus_pkg::TAG_HI,
  parameter int unsigned                TAG_LO    = de10_bus_pkg::TAG_LO,
  parameter logic [TAG_HI-TAG_LO:0]     SDRAM_TAG = (TAG_HI-TAG_LO+1)'(de10_bus_pkg::SDRAM_TAG),
  parameter int unsigned                TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ack,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ack,
  output logic                m1_err,
  output logic                en_sdram,
  output logic                en_periph,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic [DATA_W-1:0]   sdram_rdata,
  input  logic                sdram_ready,
  input  logic [DATA_W-1:0]   per_rdata,
  input  logic                per_ready
);

  import de10_bus_pkg::*;

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned TW    = TAG_HI - TAG_LO + 1;
  localparam int unsigned CNT_W = 8;

  state_e              state_q,     state_d;
  master_e             rr_last_q,   rr_last_d;
  logic [CNT_W-1:0]    tmo_cnt_q,   tmo_cnt_d;
  logic                en_sdram_q,  en_sdram_d;
  logic                en_periph_q, en_periph_d;
  logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
  logic                bus_we_q,    bus_we_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [BE_W-1:0]     bus_be_q,    bus_be_d;
  logic [DATA_W-1:0]   m0_rdata_q,  m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q,  m1_rdata_d;
  logic                m0_ack_q,    m0_ack_d;
  logic                m0_err_q,    m0_err_d;
  logic                m1_ack_q,    m1_ack_d;
  logic                m1_err_q,    m1_err_d;

  master_e             win_c;
  logic [ADDR_W-1:0]   win_addr_c;
  logic                sel_sdram_c;
  logic                sel_periph_c;
  logic                sel_ready_c;
  logic [DATA_W-1:0]   sel_rdata_c;

  // Round-robin pick: on a tie the master that did not win last time goes.
  always_comb begin
    win_c = M0;
    if (m0_req && m1_req) begin
      win_c = (rr_last_q == M0) ? M1 : M0;
    end else if (m1_req) begin
      win_c = M1;
    end
  end

  assign win_addr_c = (win_c == M1) ? m1_addr : m0_addr;

  de10_region_decode #(
    .TAG_W     (TW),
    .SDRAM_TAG (SDRAM_TAG)
  ) u_region_decode (
    .tag_i          (win_addr_c[TAG_HI:TAG_LO]),
    .sel_sdram_c_o  (sel_sdram_c),
    .sel_periph_c_o (sel_periph_c)
  );

  // Only the selected target's handshake is ever observed.
  assign sel_ready_c = (en_sdram_q & sdram_ready) | (en_periph_q & per_ready);
  assign sel_rdata_c = en_sdram_q ? sdram_rdata : per_rdata;

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    tmo_cnt_d   = tmo_cnt_q;
    en_sdram_d  = en_sdram_q;
    en_periph_d = en_periph_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_ack_d    = 1'b0;
    m0_err_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m1_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          rr_last_d   = win_c;
          bus_addr_d  = win_addr_c;
          bus_we_d    = (win_c == M1) && m1_we;
          bus_wdata_d = (win_c == M1) ? m1_wdata : '0;
          bus_be_d    = (win_c == M1) ? m1_be : '1;
          en_sdram_d  = sel_sdram_c;
          en_periph_d = sel_periph_c;
          tmo_cnt_d   = '0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        if (sel_ready_c) begin
          en_sdram_d  = 1'b0;
          en_periph_d = 1'b0;
          if (rr_last_q == M1) begin
            m1_rdata_d = bus_we_q ? '0 : sel_rdata_c;
            m1_ack_d   = 1'b1;
          end else begin
            m0_rdata_d = bus_we_q ? '0 : sel_rdata_c;
            m0_ack_d   = 1'b1;
          end
          state_d = RESP;
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Hung target: release the bus and report an error ack.
          en_sdram_d  = 1'b0;
          en_periph_d = 1'b0;
          if (rr_last_q == M1) begin
            m1_rdata_d = '0;
            m1_ack_d   = 1'b1;
            m1_err_d   = 1'b1;
          end else begin
            m0_rdata_d = '0;
            m0_ack_d   = 1'b1;
            m0_err_d   = 1'b1;
          end
          state_d = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_last_q   <= M1;
      tmo_cnt_q   <= '0;
      en_sdram_q  <= 1'b0;
      en_periph_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      tmo_cnt_q   <= tmo_cnt_d;
      en_sdram_q  <= en_sdram_d;
      en_periph_q <= en_periph_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_ack_q    <= m0_ack_d;
      m0_err_q    <= m0_err_d;
      m1_ack_q    <= m1_ack_d;
      m1_err_q    <= m1_err_d;
    end
  end

  assign en_sdram  = en_sdram_q;
  assign en_periph = en_periph_q;
  assign bus_addr  = bus_addr_q;
  assign bus_we    = bus_we_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be    = bus_be_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_ack    = m0_ack_q;
  assign m0_err    = m0_err_q;
  assign m1_ack    = m1_ack_q;
  assign m1_err    = m1_err_q;

endmodule
